// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M execute unit: iterative shift-add multiplier and restoring
// divider behind a valid/ready handshake, with flush and divide special cases.
module ex_muldiv_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_WIDTH = 5,
  parameter int MUL_STEP       = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      flush_i,
  input  logic [2:0]                funct3_i,
  input  logic [DATA_WIDTH-1:0]     data_a_i,
  input  logic [DATA_WIDTH-1:0]     data_b_i,
  input  logic [REGISTER_WIDTH-1:0] rd_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DATA_WIDTH-1:0]     result_o,
  output logic [REGISTER_WIDTH-1:0] rd_o,
  output logic                      busy_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] MUL_ITER = CW'(DATA_WIDTH / MUL_STEP);
  localparam logic [CW-1:0] DIV_ITER = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [W-1:0]  MIN_VAL  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]                funct3_q;
  logic [REGISTER_WIDTH-1:0] rd_q;
  logic                      neg_q;
  logic [CW-1:0]             cnt_q;
  logic [2*W-1:0]            prod_q;
  logic [2*W-1:0]            mcand_q;
  logic [W-1:0]              mplier_q;
  logic [W-1:0]              result_q;

  logic           accept;
  logic           a_sgn, b_sgn, sa, sb, neg_in;
  logic [W-1:0]   mag_a, mag_b;
  logic           div_zero, div_ovf, special;
  logic [W-1:0]   spec_quo, spec_rem;
  logic [CW-1:0]  limit;
  logic           last;
  logic [2*W-1:0] mul_sum;
  logic [W:0]     div_shift, div_diff;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] mul_fin;
  logic [W-1:0]   div_sel, div_fin, fin;

  assign accept = (state_q == S_IDLE) && valid_i && !flush_i;

  // Operand decode: signedness, magnitudes, result sign and divide special cases.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b010:                         a_sgn = 1'b1;
      default: ;
    endcase
    sa       = a_sgn & data_a_i[W-1];
    sb       = b_sgn & data_b_i[W-1];
    mag_a    = sa ? -data_a_i : data_a_i;
    mag_b    = sb ? -data_b_i : data_b_i;
    // Remainder takes the dividend's sign; every other op uses sa^sb (zero when unsigned).
    neg_in   = (funct3_i == 3'b110) ? sa : (sa ^ sb);
    div_zero = funct3_i[2] && (data_b_i == '0);
    div_ovf  = funct3_i[2] && !funct3_i[0] && (data_a_i == MIN_VAL) && (data_b_i == '1);
    special  = div_zero || div_ovf;
    spec_quo = div_zero ? '1 : MIN_VAL;
    spec_rem = div_zero ? data_a_i : '0;
  end

  always_comb begin
    limit = (state_q == S_MUL) ? MUL_ITER : DIV_ITER;
    last  = (cnt_q == limit);
  end

  always_comb begin
    mul_sum = prod_q;
    for (int unsigned i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) mul_sum = mul_sum + (mcand_q << i);
    end
  end

  // Divide state packs {remainder, dividend/quotient} into prod_q.
  always_comb begin
    div_shift = {prod_q[2*W-1:W], prod_q[W-1]};
    div_diff  = div_shift - {1'b0, mplier_q};
    if (!div_diff[W]) div_next = {div_diff[W-1:0], prod_q[W-2:0], 1'b1};
    else              div_next = {div_shift[W-1:0], prod_q[W-2:0], 1'b0};
  end

  always_comb begin
    mul_fin = neg_q ? -prod_q : prod_q;
    div_sel = funct3_q[1] ? prod_q[2*W-1:W] : prod_q[W-1:0];
    div_fin = neg_q ? -div_sel : div_sel;
    if (state_q == S_MUL) fin = (funct3_q == 3'b000) ? mul_fin[W-1:0] : mul_fin[2*W-1:W];
    else                  fin = div_fin;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Special divides enter DIV with the counter at its limit, so they finalize next edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (funct3_i[2] || special) ? S_DIV : S_MUL;
      S_MUL, S_DIV: begin
        if (flush_i)   state_d = S_IDLE;
        else if (last) state_d = S_DONE;
      end
      S_DONE: if (flush_i || ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o  = (state_q == S_IDLE);
    busy_o   = (state_q != S_IDLE);
    valid_o  = (state_q == S_DONE);
    result_o = result_q;
    rd_o     = rd_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      funct3_q <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
    end else if (accept) begin
      funct3_q <= funct3_i;
      rd_q     <= rd_i;
      mplier_q <= mag_b;
      mcand_q  <= {{W{1'b0}}, mag_a};
      if (special) begin
        neg_q  <= 1'b0;
        cnt_q  <= DIV_ITER;
        prod_q <= {spec_rem, spec_quo};
      end else begin
        neg_q  <= neg_in;
        cnt_q  <= '0;
        prod_q <= funct3_i[2] ? {{W{1'b0}}, mag_a} : '0;
      end
    end else if ((state_q == S_MUL || state_q == S_DIV) && !flush_i) begin
      if (last) begin
        result_q <= fin;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
        if (state_q == S_MUL) begin
          prod_q   <= mul_sum;
          mcand_q  <= mcand_q << MUL_STEP;
          mplier_q <= mplier_q >> MUL_STEP;
        end else begin
          prod_q <= div_next;
        end
      end
    end
  end

endmodule
